// File: rtl/cnn_layer_sequencer.sv
// Fixed-order layer launcher for the CNN pipeline: start/done handshakes,
// a per-stage watchdog and whole-pass latency measurement.
module cnn_layer_sequencer #(
  parameter int N_STAGES       = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  localparam int AW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 abort,
  output logic [N_STAGES-1:0]  stage_start,
  input  logic [N_STAGES-1:0]  stage_done,
  output logic [AW-1:0]        active_stage,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic [CNT_WIDTH-1:0] total_cycles
);

  localparam logic [AW-1:0] LAST = AW'(N_STAGES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LIM = CNT_WIDTH'(TIMEOUT_CYCLES);
  // a limit the timer cannot represent can never expire
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0) &&
                         ((longint'(TIMEOUT_CYCLES) >> CNT_WIDTH) == 0);

  localparam logic [1:0] E_NONE = 2'd0;
  localparam logic [1:0] E_TMO  = 2'd1;
  localparam logic [1:0] E_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FINISH
  } state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         k_q, k_d;
  logic [N_STAGES-1:0]   start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [1:0]            code_q, code_d;
  logic [CNT_WIDTH-1:0]  lat_q, lat_d;
  logic [CNT_WIDTH-1:0]  tmr_q, tmr_d;
  logic [CNT_WIDTH-1:0]  total_q, total_d;

  logic [N_STAGES-1:0]   k_mask;
  logic                  hit;
  logic                  stray;
  logic                  timeout;
  logic [CNT_WIDTH-1:0]  lat_inc;
  logic [CNT_WIDTH-1:0]  tmr_inc;

  always_comb begin
    k_mask  = N_STAGES'(1) << k_q;
    hit     = |(stage_done & k_mask);
    stray   = |(stage_done & ~k_mask);
    timeout = WD_EN && (tmr_q == TO_LIM);
    lat_inc = (&lat_q) ? lat_q : lat_q + CNT_WIDTH'(1);
    tmr_inc = (&tmr_q) ? tmr_q : tmr_q + CNT_WIDTH'(1);

    state_d = state_q;
    k_d     = k_q;
    start_d = '0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    code_d  = code_q;
    lat_d   = lat_q;
    tmr_d   = tmr_q;
    total_d = total_q;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (run && !abort) begin
          state_d = S_WAIT;
          k_d     = '0;
          start_d = N_STAGES'(1);
          busy_d  = 1'b1;
          error_d = 1'b0;
          code_d  = E_NONE;
          lat_d   = CNT_WIDTH'(1);
          tmr_d   = '0;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (stray) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          error_d = 1'b1;
          code_d  = E_DONE;
        end else if (hit) begin
          if (k_q == LAST) begin
            state_d = S_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            total_d = lat_q;
          end else begin
            k_d     = k_q + AW'(1);
            start_d = k_mask << 1;
            tmr_d   = '0;
            lat_d   = lat_inc;
          end
        end else if (timeout) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          error_d = 1'b1;
          code_d  = E_TMO;
        end else begin
          tmr_d = tmr_inc;
          lat_d = lat_inc;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      start_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= E_NONE;
      lat_q   <= '0;
      tmr_q   <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      code_q  <= code_d;
      lat_q   <= lat_d;
      tmr_q   <= tmr_d;
      total_q <= total_d;
    end
  end

  assign stage_start  = start_q;
  assign active_stage = k_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = code_q;
  assign total_cycles = total_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer: engine models answer start
// pulses; expected starts/dones are queued and matched as they appear.
module tb_cnn_layer_sequencer;
  localparam int N  = 4;
  localparam int CW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic          abort;
  logic [N-1:0]  stage_start;
  logic [N-1:0]  stage_done;
  logic [1:0]    active_stage;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [CW-1:0] total_cycles;

  always #5 clk = ~clk;

  cnn_layer_sequencer #(
    .N_STAGES(N),
    .CNT_WIDTH(CW),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .run(run),
    .abort(abort),
    .stage_start(stage_start),
    .stage_done(stage_done),
    .active_stage(active_stage),
    .busy(busy),
    .done(done),
    .error(error),
    .err_code(err_code),
    .total_cycles(total_cycles)
  );

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t st_q[$];
  ev_t dn_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;
  int  lat[N];
  int  due[N];
  int  b_lo1, b_hi1, b_lo2, b_hi2;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic in_win(input int c);
    return (c >= b_lo1 && c <= b_hi1) || (c >= b_lo2 && c <= b_hi2);
  endfunction

  task automatic win(input int a, input int b, input int c, input int d);
    b_lo1 = a; b_hi1 = b; b_lo2 = c; b_hi2 = d;
  endtask

  // starts follow done by one cycle; total counts from the start cycle
  task automatic push_pass(input int base, input int n);
    int s;
    s = base + 1;
    for (int i = 0; i < n; i++) begin
      st_q.push_back(ev_t'{s, i});
      if (i < N - 1) s = s + lat[i] + 1;
    end
    if (n == N)
      dn_q.push_back(ev_t'{s + lat[N-1] + 1, s + lat[N-1] - base});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      ev_t e;
      chk("busy", busy, in_win(cyc));
      if (stage_start != '0) begin
        if (st_q.size() == 0) begin
          chk("start_extra", stage_start, 0);
        end else begin
          e = st_q.pop_front();
          chk("start_cyc", cyc, e.cyc);
          chk("start_vec", stage_start, N'(1) << e.val);
          chk("active", active_stage, e.val);
        end
      end
      if (done) begin
        if (dn_q.size() == 0) begin
          chk("done_extra", done, 0);
        end else begin
          e = dn_q.pop_front();
          chk("done_cyc", cyc, e.cyc);
          chk("total", total_cycles, e.val);
        end
      end
    end
  end

  task automatic sim(input int ncyc, input int rf, input int rt,
                     input int ab, input int sa, input int sb,
                     input int hang, input int ra);
    for (int i = 0; i < N; i++) due[i] = -1;
    cyc = 0;
    mon_en = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < N; i++)
        if (stage_start[i] && i != hang) due[i] = c + lat[i];
      for (int i = 0; i < N; i++) stage_done[i] = (due[i] == c);
      if (c == sa) stage_done[sb] = 1'b1;
      run   = (c >= rf && c <= rt);
      abort = (c == ab);
      reset = (c == ra);
      @(posedge clk);
      cyc++;
      #1;
    end
    mon_en = 1'b0;
    run = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
    stage_done = '0;
    chk("start_left", st_q.size(), 0);
    chk("done_left", dn_q.size(), 0);
    st_q.delete();
    dn_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start"}, stage_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, error, 0);
    chk({tag, "_code"}, err_code, 0);
    chk({tag, "_total"}, total_cycles, 0);
    chk({tag, "_active"}, active_stage, 0);
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    abort = 1'b0;
    stage_done = '0;
    lat = '{5, 3, 7, 2};
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_zero("rst");

    // nominal pass
    win(1, 21, 1, 0);
    push_pass(0, N);
    sim(24, 0, 0, -1, -1, 0, -1, -1);
    chk("nom_err", error, 0);
    chk("nom_code", err_code, 0);
    chk("nom_total", total_cycles, 21);

    // done exactly at the watchdog limit is accepted
    lat[0] = TO;
    win(1, 32, 1, 0);
    push_pass(0, N);
    sim(35, 0, 0, -1, -1, 0, -1, -1);
    chk("edge_err", error, 0);
    chk("edge_total", total_cycles, 32);
    lat[0] = 5;

    // stage 1 hangs
    win(1, 23, 1, 0);
    push_pass(0, 2);
    sim(24, 0, 0, -1, -1, 0, 1, -1);
    chk("wd_err", error, 1);
    chk("wd_code", err_code, 1);
    chk("wd_busy", busy, 0);
    chk("wd_total", total_cycles, 32);

    // rerun clears the fault
    win(1, 21, 1, 0);
    push_pass(0, N);
    sim(24, 0, 0, -1, -1, 0, -1, -1);
    chk("rerun_err", error, 0);
    chk("rerun_code", err_code, 0);
    chk("rerun_total", total_cycles, 21);

    // stray done from stage 2 while stage 1 runs
    win(1, 8, 1, 0);
    push_pass(0, 2);
    sim(12, 0, 0, -1, 8, 2, -1, -1);
    chk("stray_err", error, 1);
    chk("stray_code", err_code, 2);
    chk("stray_busy", busy, 0);
    chk("stray_total", total_cycles, 21);

    // run with abort in idle does nothing; fault stays
    win(1, 0, 1, 0);
    sim(4, 0, 0, 0, -1, 0, -1, -1);
    chk("ra_busy", busy, 0);
    chk("ra_err", error, 1);
    chk("ra_code", err_code, 2);

    // abort collides with stage 1 done
    win(1, 10, 1, 0);
    push_pass(0, 2);
    sim(14, 0, 0, 10, -1, 0, -1, -1);
    chk("ab_err", error, 0);
    chk("ab_code", err_code, 0);
    chk("ab_total", total_cycles, 21);

    // run held across two passes
    win(1, 21, 24, 44);
    push_pass(0, N);
    push_pass(23, N);
    sim(48, 0, 44, -1, -1, 0, -1, -1);
    chk("hold_total", total_cycles, 21);

    // reset while stage 2 runs
    win(1, 13, 1, 0);
    push_pass(0, 3);
    sim(14, 0, 0, -1, -1, 0, -1, 13);
    chk_zero("midrst");

    win(1, 21, 1, 0);
    push_pass(0, N);
    sim(24, 0, 0, -1, -1, 0, -1, -1);
    chk("post_err", error, 0);
    chk("post_total", total_cycles, 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
